td4_register_bank: RTL and testbench

//   Register stage of the TD4 datapath, directly downstream of the 3-input NAND

---
 rtl/td4_register_bank.sv | 60 ++++++
 tb/tb_td4_register_bank.sv | 128 ++++++++++++
 2 files changed

// File: rtl/td4_register_bank.sv
// td4_register_bank: TD4 register stage holding A, B, OUT, PC and the carry flag.
//   clk        rising-edge clock
//   n_reset    asynchronous active-low clear of every register
//   load_n     active-low load strobes: [0]=A [1]=B [2]=OUT [3]=PC
//   data_in    ALU sum, captured by every strobed register
//   carry_in   ALU carry-out, sampled every cycle into carry_flag
//   reg_a      register A
//   reg_b      register B
//   reg_out    output port register
//   pc         program counter / ROM address
//   carry_flag registered carry
//   pc_rco     PC ripple carry, high while counting is enabled and pc is all-ones
module td4_register_bank #(
    parameter int WIDTH    = 4,
    parameter bit PC_COUNT = 1'b1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [3:0]       load_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             carry_in,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic [WIDTH-1:0] reg_out,
    output logic [WIDTH-1:0] pc,
    output logic             carry_flag,
    output logic             pc_rco
);
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d, pc_q, pc_d;
    logic             carry_q, carry_d;
    always_comb begin
        a_d     = load_n[0] ? a_q : data_in;
        b_d     = load_n[1] ? b_q : data_in;
        out_d   = load_n[2] ? out_q : data_in;
        // load beats count; a dropped increment is intentional
        pc_d    = !load_n[3] ? data_in : (PC_COUNT ? pc_q + 1'b1 : pc_q);
        carry_d = carry_in;
    end
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            pc_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            pc_q    <= pc_d;
            carry_q <= carry_d;
        end
    end
    assign reg_a      = a_q;
    assign reg_b      = b_q;
    assign reg_out    = out_q;
    assign pc         = pc_q;
    assign carry_flag = carry_q;
    assign pc_rco     = PC_COUNT && (pc_q == {WIDTH{1'b1}});
endmodule

// File: tb/tb_td4_register_bank.sv
// tb_td4_register_bank: scoreboard bench for td4_register_bank.
module tb_td4_register_bank;
    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [3:0] load_n = 4'hF;
    logic [3:0] data_in = 4'h0;
    logic       carry_in = 1'b0;
    logic [3:0] reg_a, reg_b, reg_out, pc;
    logic       carry_flag, pc_rco;

    td4_register_bank #(.WIDTH(4), .PC_COUNT(1'b1)) dut (
        .clk(clk), .n_reset(n_reset), .load_n(load_n), .data_in(data_in),
        .carry_in(carry_in), .reg_a(reg_a), .reg_b(reg_b), .reg_out(reg_out),
        .pc(pc), .carry_flag(carry_flag), .pc_rco(pc_rco)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] a, b, o, p;
        logic       c, r;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    event chk_ev;
    logic [3:0] ma = 0, mb = 0, mo = 0, mp = 0;
    logic       mc = 0;

    task automatic cmp(input string tag, input string f, input logic [3:0] act, input logic [3:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", tag, f, act, want);
        end
    endtask

    // monitor: pops expectations after each edge or on an immediate-check request
    initial forever begin
        @(posedge clk or chk_ev);
        #1;
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.tag, "reg_a", reg_a, e.a);
            cmp(e.tag, "reg_b", reg_b, e.b);
            cmp(e.tag, "reg_out", reg_out, e.o);
            cmp(e.tag, "pc", pc, e.p);
            cmp(e.tag, "carry", {3'b0, carry_flag}, {3'b0, e.c});
            cmp(e.tag, "rco", {3'b0, pc_rco}, {3'b0, e.r});
        end
    end

    task automatic push(input string tag);
        exp_t e;
        e.tag = tag; e.a = ma; e.b = mb; e.o = mo; e.p = mp; e.c = mc; e.r = (mp == 4'hF);
        q.push_back(e);
    endtask

    task automatic model_clear();
        ma = 0; mb = 0; mo = 0; mp = 0; mc = 0;
    endtask

    // drive at the falling edge, expectation holds after the next rising edge
    task automatic step(input string tag, input logic [3:0] ln, input logic [3:0] d,
                        input logic ci, input logic rn);
        @(negedge clk);
        load_n = ln; data_in = d; carry_in = ci; n_reset = rn;
        if (!rn) model_clear();
        else begin
            if (!ln[0]) ma = d;
            if (!ln[1]) mb = d;
            if (!ln[2]) mo = d;
            mp = !ln[3] ? d : mp + 4'd1;
            mc = ci;
        end
        push(tag);
    endtask

    initial begin
        // reset with random strobes: everything cleared and held
        #2;
        load_n = 4'($urandom); data_in = 4'($urandom); carry_in = 1'b1;
        model_clear();
        push("reset_now");
        -> chk_ev;
        for (int i = 0; i < 3; i++)
            step("reset_hold", 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
        // free count: pc 1..F,0,1 across 17 edges
        for (int i = 0; i < 17; i++) step("count", 4'hF, 4'h0, 1'b0, 1'b1);
        step("load_a", 4'b1110, 4'h5, 1'b1, 1'b1);
        step("pc_to_3", 4'b0111, 4'h3, 1'b0, 1'b1);
        step("jump", 4'b0111, 4'hA, 1'b0, 1'b1);
        step("after_jump", 4'hF, 4'h0, 1'b0, 1'b1);
        step("multi_load", 4'b0000, 4'h9, 1'b1, 1'b1);
        step("load_b_out", 4'b1001, 4'hC, 1'b0, 1'b1);
        step("pc_to_6", 4'b0111, 4'h6, 1'b1, 1'b1);
        step("pc_to_7", 4'hF, 4'h0, 1'b1, 1'b1);
        // async clear mid-cycle, ahead of the next edge
        @(posedge clk);
        #3;
        n_reset = 1'b0;
        model_clear();
        #1;
        push("async_clear");
        -> chk_ev;
        step("async_hold", 4'b0000, 4'hE, 1'b1, 1'b0);
        step("release", 4'hF, 4'h0, 1'b1, 1'b1);
        step("release2", 4'hF, 4'h0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
